rr_stream_arbiter_2to1: RTL and testbench

- Front end that feeds the 2-request round-robin grant logic.
- Two independent valid/ready producer streams each land in a private FIFO; FIFO non-empty flags form the 2-bit request vector.
- Round-robin arbitration pops one FIFO per cycle into a registered valid/ready output stage, tagged with its source index.
- Output drives a single shared consumer.

---
 rtl/rr_stream_arbiter_2to1.sv | 159 +++++++++++++++
 tb/tb_rr_stream_arbiter_2to1.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rr_stream_arbiter_2to1.sv
// rr_stream_arbiter_2to1
//   Two valid/ready producer streams, each buffered in a private FIFO, are
//   merged round-robin onto one registered valid/ready output tagged with
//   the source index.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous, active-high reset
//   in0_valid  stream 0 data valid
//   in0_ready  stream 0 FIFO can accept (not full)
//   in0_data   stream 0 payload
//   in1_valid  stream 1 data valid
//   in1_ready  stream 1 FIFO can accept (not full)
//   in1_data   stream 1 payload
//   out_valid  output register holds a word
//   out_ready  consumer accepts
//   out_data   granted payload
//   out_src    source of out_data (0 or 1)

// Per-stream FIFO. The head word is read combinationally, and it only
// reflects writes from earlier edges, so a new word becomes visible one
// cycle after its push.
module rr_stream_arbiter_2to1_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
endmodule

module rr_stream_arbiter_2to1 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CW-1:0]    count0, count1;
  logic [WIDTH-1:0] head0, head1;
  logic             push0, push1;
  logic             pop0, pop1;
  logic [1:0]       req;
  logic             load;
  logic             grant1;
  logic             prio;   // 0: stream 0 wins a tie, 1: stream 1 wins

  // Ready depends only on the stored count, so a full FIFO refuses a push
  // even in the cycle it is being popped.
  assign in0_ready = (count0 != FULL_CNT);
  assign in1_ready = (count1 != FULL_CNT);
  assign push0     = in0_valid & in0_ready;
  assign push1     = in1_valid & in1_ready;

  assign req  = {(count1 != '0), (count0 != '0)};
  assign load = (~out_valid | out_ready) & (req != 2'b00);

  always_comb begin
    grant1 = 1'b0;
    case (req)
      2'b10:   grant1 = 1'b1;
      2'b11:   grant1 = prio;
      default: grant1 = 1'b0;
    endcase
  end

  assign pop0 = load & ~grant1;
  assign pop1 = load &  grant1;

  rr_stream_arbiter_2to1_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (in0_data),
    .pop       (pop0),
    .head      (head0),
    .count     (count0)
  );

  rr_stream_arbiter_2to1_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (in1_data),
    .pop       (pop1),
    .head      (head1),
    .count     (count1)
  );

  // Output register plus round-robin pointer. Priority moves only when a
  // word is actually loaded; on drain, data and source keep their values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      prio      <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= grant1 ? head1 : head0;
      out_src   <= grant1;
      prio      <= ~grant1;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_stream_arbiter_2to1.sv
module tb_rr_stream_arbiter_2to1;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in0_valid = 1'b0, in1_valid = 1'b0;
  logic             in0_ready, in1_ready;
  logic [WIDTH-1:0] in0_data = '0, in1_data = '0;
  logic             out_valid, out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_src;

  always #5 clk = ~clk;

  rr_stream_arbiter_2to1 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one queue per source, the word sitting in the output
  // register, and the index of the source granted most recently.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_src;
  int               last_src;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_valid  = 1'b0;
    m_data   = '0;
    m_src    = 1'b0;
    last_src = 1;  // stream 0 is next in line after reset
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("out_src",   32'(out_src),   32'(m_src));
    check("in0_ready", 32'(in0_ready), 32'(q0.size() < DEPTH));
    check("in1_ready", 32'(in1_ready), 32'(q1.size() < DEPTH));
  endtask

  // Called at a falling edge: check, drive, advance model, run one cycle.
  task automatic step(input bit v0, input logic [WIDTH-1:0] d0,
                      input bit v1, input logic [WIDTH-1:0] d1, input bit rdy);
    bit acc0, acc1;
    int pick;
    check_outputs();
    in0_valid = v0; in0_data = d0;
    in1_valid = v1; in1_data = d1;
    out_ready = rdy;
    acc0 = v0 && (q0.size() < DEPTH);
    acc1 = v1 && (q1.size() < DEPTH);
    // Selection uses only words stored before this edge (no bypass).
    if ((!m_valid || rdy) && (q0.size() > 0 || q1.size() > 0)) begin
      if (q0.size() == 0)      pick = 1;
      else if (q1.size() == 0) pick = 0;
      else                     pick = 1 - last_src;
      m_data   = (pick == 0) ? q0.pop_front() : q1.pop_front();
      m_src    = pick[0];
      m_valid  = 1'b1;
      last_src = pick;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (acc0) q0.push_back(d0);
    if (acc1) q1.push_back(d1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, rdy);
  endtask

  task automatic random_phase(input int cycles, input int pv0, input int pv1, input int pr);
    for (int i = 0; i < cycles; i++)
      step($urandom_range(99) < pv0, WIDTH'($urandom),
           $urandom_range(99) < pv1, WIDTH'($urandom),
           $urandom_range(99) < pr);
  endtask

  initial begin
    bit [1:0] pats [10] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11,
                             2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single source burst with an always-ready consumer.
    step(1, 8'h11, 0, '0, 1);
    step(1, 8'h22, 0, '0, 1);
    step(1, 8'h33, 0, '0, 1);
    idle(4, 1);

    // Request patterns exercising the remembered priority.
    for (int i = 0; i < 10; i++) begin
      step(pats[i][0], WIDTH'(8'h40 + i), pats[i][1], WIDTH'(8'h80 + i), 1);
      idle(3, 1);
    end

    // Stalled consumer: fill both FIFOs past full, then release.
    for (int i = 0; i < 6; i++)
      step(1, WIDTH'(8'hA0 + i), 1, WIDTH'(8'hB0 + i), 0);
    idle(12, 1);

    // Steady single stream, consumer always ready.
    for (int i = 0; i < 20; i++) step(1, WIDTH'(i), 0, '0, 1);
    idle(3, 1);

    random_phase(300, 50, 50, 50);
    random_phase(300, 90, 90, 100);
    random_phase(300, 90, 30, 20);
    random_phase(300, 20, 80, 70);

    // Asynchronous reset mid-burst with words buffered in both FIFOs.
    for (int i = 0; i < 3; i++)
      step(1, WIDTH'(8'hC0 + i), 1, WIDTH'(8'hD0 + i), 0);
    @(posedge clk);
    #2;
    rst       = 1'b1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1, 8'h5A, 1, 8'hA5, 1);
    idle(4, 1);

    random_phase(300, 70, 70, 60);
    idle(10, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
